// File: rtl/ps2_rx_frame_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, frame constants
// and the odd-parity helper.
package ps2_rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 11;

  // Parity bit that makes the total number of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Scan-code FIFO: power-of-two DEPTH, head reads 0 when empty, push while
// full succeeds only alongside a pop.
module ps2_rx_fifo
  import ps2_rx_frame_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_BITS-1:0]       push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DATA_BITS-1:0]       head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    count = cnt_q;
    head  = empty ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: sync + glitch filter, 11-bit deframer
// with parity/framing/timeout checks, scan-code FIFO. PS2_RX_INHIBIT_EN adds ps2_clk_oe.
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_data,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_overflow
`ifdef PS2_RX_INHIBIT_EN
  ,
  output logic       ps2_clk_oe
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic          clk_f_q, clk_f_d, data_f_q, data_f_d, clk_fp_q;
  logic [7:0]    clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          err_parity_q, err_parity_d, err_frame_q, err_frame_d;
  logic          err_overflow_q, err_overflow_d;
  logic          fall, timeout, push, inhibit;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Filter: the output follows the synchronised line only after FILTER_LEN
  // consecutive disagreeing samples; inhibit pins the clock filter high.
  always_comb begin
    clk_f_d    = clk_f_q;
    clk_cnt_d  = '0;
    data_f_d   = data_f_q;
    data_cnt_d = '0;
    if (inhibit) begin
      clk_f_d = 1'b1;
    end else if (clk_s2_q != clk_f_q) begin
      if (clk_cnt_q == 8'(FILTER_LEN - 1)) clk_f_d = clk_s2_q;
      else clk_cnt_d = clk_cnt_q + 8'd1;
    end
    if (data_s2_q != data_f_q) begin
      if (data_cnt_q == 8'(FILTER_LEN - 1)) data_f_d = data_s2_q;
      else data_cnt_d = data_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      clk_f_q    <= 1'b1;
      data_f_q   <= 1'b1;
      clk_fp_q   <= 1'b1;
      clk_cnt_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
      clk_f_q    <= clk_f_d;
      data_f_q   <= data_f_d;
      clk_fp_q   <= clk_f_q;
      clk_cnt_q  <= clk_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  assign fall    = clk_fp_q && !clk_f_q && !inhibit;
  assign timeout = (state_q != ST_IDLE) && !fall && (tmo_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      parity_q       <= 1'b0;
      tmo_q          <= '0;
      err_parity_q   <= 1'b0;
      err_frame_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      parity_q       <= parity_d;
      tmo_q          <= tmo_d;
      err_parity_q   <= err_parity_d;
      err_frame_q    <= err_frame_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tmo_d    = '0;
    if (fall) begin
      case (state_q)
        ST_IDLE: if (!data_f_q) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
        ST_DATA: begin
          shreg_d  = {data_f_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'(DATA_BITS - 1)) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_f_q;
          state_d  = ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE) begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_comb begin
    push         = 1'b0;
    err_parity_d = 1'b0;
    err_frame_d  = timeout;
    if (fall) begin
      case (state_q)
        ST_IDLE: err_frame_d = data_f_q;
        ST_STOP: begin
          if (!data_f_q) err_frame_d = 1'b1;
          else if (parity_q != odd_parity(shreg_q)) err_parity_d = 1'b1;
          else push = 1'b1;
        end
        default: ;
      endcase
    end
    // A full FIFO always has a head, so code_ready alone decides the pop.
    err_overflow_d = push && fifo_full && !code_ready;
  end

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg_q),
    .pop       (code_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (code_data)
  );

`ifdef PS2_RX_INHIBIT_EN
  logic inhibit_q, inhibit_d;

  // Only start inhibiting between frames; once asserted, hold until drained.
  always_comb begin
    inhibit_d = (fifo_count >= CW'(FIFO_DEPTH - 1)) && (inhibit_q || state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) inhibit_q <= 1'b0;
    else       inhibit_q <= inhibit_d;
  end

  assign inhibit    = inhibit_q;
  assign ps2_clk_oe = inhibit_q;
`else
  logic unused_count;
  assign unused_count = ^fifo_count;
  assign inhibit      = 1'b0;
`endif

  assign code_valid   = !fifo_empty;
  assign err_parity   = err_parity_q;
  assign err_frame    = err_frame_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Self-checking bench for ps2_rx_frame: directed frames plus randomized traffic
// against a queue-based model of the received-code stream.
module tb_ps2_rx_frame;
  import ps2_rx_frame_pkg::*;

  localparam int unsigned FL    = 4;
  localparam int unsigned TO    = 400;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned HALF  = 30;
  localparam int unsigned LATW  = FL + 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_ready = 1'b0;
  logic [7:0] code_data;
  logic       code_valid, err_parity, err_frame, err_overflow;
`ifdef PS2_RX_INHIBIT_EN
  logic       ps2_clk_oe;
`endif

  int checks = 0;
  int errors = 0;

  // Requests from the stimulus process to the model/compare process.
  int         req_seq = 0;
  logic [7:0] req_code = '0;
  bit         req_push = 0, req_par = 0, req_frm = 0;
  int         req_len = 0;

  // Owned by the compare process.
  byte unsigned q[$];
  int         ack_seq = 0;
  int         win = 0;
  int         exp_par = 0, exp_frm = 0, exp_ovf = 0;
  int         obs_par = 0, obs_frm = 0, obs_ovf = 0;
  int         vcnt = 0;
  logic [7:0] vdata = '0;

  always #5 clk = ~clk;

  ps2_rx_frame #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .code_data    (code_data),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_overflow (err_overflow)
`ifdef PS2_RX_INHIBIT_EN
    ,
    .ps2_clk_oe   (ps2_clk_oe)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Outside result windows the DUT must mirror the model exactly; inside a
  // window only the number of error pulses is checked when it closes.
  always @(negedge clk) begin
    if (req_seq != ack_seq) begin
      ack_seq = req_seq;
      exp_par = int'(req_par);
      exp_frm = int'(req_frm);
      exp_ovf = 0;
      if (req_push) begin
        if (q.size() >= DEPTH) exp_ovf = 1;
        else q.push_back(req_code);
      end
      win = req_len;
      vcnt = 0;
      obs_par = 0; obs_frm = 0; obs_ovf = 0;
    end
    if (reset) begin
      q.delete();
    end else if (win > 0) begin
      obs_par += int'(err_parity);
      obs_frm += int'(err_frame);
      obs_ovf += int'(err_overflow);
      if (code_valid) begin
        vcnt++;
        vdata = code_data;
      end
      win--;
      if (win == 0) begin
        chk("err_parity_pulses", obs_par, exp_par);
        chk("err_frame_pulses", obs_frm, exp_frm);
        chk("err_overflow_pulses", obs_ovf, exp_ovf);
      end
      if (code_ready && q.size() > 0) void'(q.pop_front());
    end else begin
      chk("code_valid", code_valid, q.size() != 0);
      chk("code_data", code_data, (q.size() != 0) ? q[0] : 8'h00);
      chk("no_err_pulse", {err_parity, err_frame, err_overflow}, 3'b000);
      if (code_ready && q.size() > 0) void'(q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [7:0] code, input bit push, input bit par, input bit frm, input int len);
    req_code = code;
    req_push = push;
    req_par  = par;
    req_frm  = frm;
    req_len  = len;
    req_seq++;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bit inhib;
    inhib = 0;
`ifdef PS2_RX_INHIBIT_EN
    inhib = (q.size() >= DEPTH - 1);
`endif
    bits = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2 - 8);
      end else begin
        wait_cyc(HALF / 2);
      end
      ps2_clk = 1'b0;
      if (i == FRAME_BITS - 1 && !inhib)
        post(b, !bad_stop && !bad_par, bad_par && !bad_stop, bad_stop, LATW);
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int kind;
    wait_cyc(5);
    chk("reset_valid", code_valid, 1'b0);
    chk("reset_data", code_data, 8'h00);
    chk("reset_errs", {err_parity, err_frame, err_overflow}, 3'b000);
    reset = 1'b0;
    wait_cyc(10);

    // Clean 0x1C with consumer ready: single-cycle valid.
    code_ready = 1'b1;
    send_frame(8'h1C, 0, 0, 11, -1);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_data", vdata, 8'h1C);

    // Two buffered codes, popped in order.
    code_ready = 1'b0;
    send_frame(8'hF0, 0, 0, 11, -1);
    send_frame(8'h1C, 0, 0, 11, -1);
    chk("t2_valid", code_valid, 1'b1);
    chk("t2_head0", code_data, 8'hF0);
    code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0;
    chk("t2_head1", code_data, 8'h1C);
    code_ready = 1'b1; wait_cyc(1); code_ready = 1'b0;
    chk("t2_empty", code_valid, 1'b0);

    // Bad parity dropped, next frame fine.
    send_frame(8'h1C, 1, 0, 11, -1);
    chk("t3_empty", code_valid, 1'b0);
    send_frame(8'h29, 0, 0, 11, -1);
    chk("t3_data", code_data, 8'h29);
    code_ready = 1'b1; wait_cyc(3); code_ready = 1'b0;

    // Five frames into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i * 8'h11), 0, 0, 11, -1);
`ifdef PS2_RX_INHIBIT_EN
      if (i == 3) chk("t4_oe", ps2_clk_oe, 1'b1);
`endif
    end
    chk("t4_head", code_data, 8'h11);
    code_ready = 1'b1; wait_cyc(8); code_ready = 1'b0;

    // Start bit of 1.
    ps2_data = 1'b1;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    post(8'h00, 0, 0, 1, LATW);
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF);

    // Stall after four data bits, then a clean frame.
    send_frame(8'hA5, 0, 0, 5, -1);
    post(8'h00, 0, 0, 1, TO + FL + 20);
    wait_cyc(TO + FL + 30);
    send_frame(8'h5A, 0, 0, 11, -1);
    chk("t6_data", code_data, 8'h5A);
    code_ready = 1'b1; wait_cyc(3); code_ready = 1'b0;

    // Short clock glitch mid-frame.
    send_frame(8'h1C, 0, 0, 11, 4);
    chk("t7_data", code_data, 8'h1C);
    code_ready = 1'b1; wait_cyc(3); code_ready = 1'b0;

    // Reset mid-frame with one code buffered.
    send_frame(8'h33, 0, 0, 11, -1);
    send_frame(8'h44, 0, 0, 5, -1);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(50);
    chk("t8_valid", code_valid, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      code_ready = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      send_frame(8'($urandom_range(0, 255)), kind == 4, kind == 5, 11,
                 (kind == 3) ? int'($urandom_range(1, 9)) : -1);
      wait_cyc(int'($urandom_range(0, 40)));
    end

    code_ready = 1'b1;
    wait_cyc(20);
    chk("final_empty", code_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
PS/2 device-to-host frame receiver that feeds the scan-code-to-key-matrix decoder. It synchronises and de-glitches ps2_clk/ps2_data and deframes the 11-bit frame: start, 8 data bits LSB first, odd parity, stop. It checks parity, framing and inter-bit timeout, and buffers good scan codes in a small FIFO with a valid/ready handshake. The decoder pops one code per accepted handshake, so no code is lost while it is busy.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered line changes (range 2..255).
TIMEOUT_CYCLES, 4000, clk cycles without a filtered falling edge before a partial frame is abandoned (range 16..65535).
FIFO_DEPTH, 4, scan-code FIFO entries (power of two, range 2..16).

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock from the pin; asynchronous.
ps2_data  in  1  raw PS/2 data from the pin; asynchronous.
code_data  out  8  scan code at the FIFO head.
code_valid  out  1  FIFO not empty.
code_ready  in  1  consumer accepts code_data this cycle.
err_parity  out  1  one-cycle pulse: frame dropped because of bad parity.
err_frame  out  1  one-cycle pulse: bad start bit, bad stop bit, or timeout.
err_overflow  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is synchronous and active-high.
- Synchronisers: two-flop synchroniser on each input, reset value 1. Filter counter per line; the filtered line takes the new value after FILTER_LEN equal samples. Filtered reset value is 1.
- Edge: fall is a one-cycle strobe when the filtered clock goes 1 to 0. The filtered data is sampled on the same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA and clear bitcnt. On fall with data=1, pulse err_frame and stay in IDLE.
  - DATA: on each fall, shift the bit into shreg[7] and shift right (LSB first), then bitcnt++. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the bit and go to STOP.
  - STOP: on fall, always return to IDLE. If data=0, pulse err_frame. Else if XOR(shreg, parity) is 0, pulse err_parity. Else push shreg.
- Timeout: the counter clears on every fall and in IDLE, and otherwise counts in any state other than IDLE. At TIMEOUT_CYCLES-1 it forces IDLE and pulses err_frame. If fall occurs in the same cycle, fall wins.
- FIFO:
  - code_valid = not empty; code_data = head entry, which is 0x00 when empty.
  - A pop happens when code_valid and code_ready are both high.
  - Push while full with no pop: the code is dropped and err_overflow pulses. Push while full with a simultaneous pop: both succeed.
  - Push while empty: code_valid rises the next cycle; there is no bypass.
- Latency: from the stop-bit fall strobe (cycle N) to code_valid=1 is N+1.
- Reset values: code_valid=0, code_data=0x00, all error outputs 0, FSM=IDLE, FIFO empty, counters 0. Reset mid-frame discards the partial frame and all buffered codes.
- Error pulses are mutually exclusive per frame, and each lasts exactly one cycle.

Optional Feature:
PS2_RX_INHIBIT_EN
- Defined:
  - Adds output ps2_clk_oe (1 bit, reset 0) to the pad, meaning ps2_clk is driven low.
  - ps2_clk_oe asserts when the FIFO holds FIFO_DEPTH-1 or more entries and the FSM is in IDLE. It deasserts once occupancy falls below FIFO_DEPTH-1.
  - While ps2_clk_oe=1, fall strobes are ignored, and the filter is held at 1 so releasing the line creates no false edge.
  - err_overflow remains but becomes unreachable under normal device behaviour.
- Undefined: the port is absent and the line is never driven; overflow drops codes as specified above.

Decomposition:
- Shared include ps2_defs.vh:
  - FSM state encodings (IDLE=0, DATA=1, PARITY=2, STOP=3).
  - Frame constants: DATA_BITS=8, FRAME_BITS=11.
  - Odd-parity function.
- One sub-module, ps2_rx_fifo: synchronous FIFO (push, pop, full, empty, count, head data), parameterised by DEPTH.
- Synchroniser, filter and FSM stay in the top.

Test Plan:
- Clean frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1), code_ready=1: code_valid pulses one cycle with code_data=0x1C; no error pulses.
- Frames 0xF0 (parity 1) then 0x1C with code_ready=0: code_valid stays high and head=0xF0. Pop yields 0x1C next; code_valid drops after the second pop.
- 0x1C sent with parity 1: err_parity pulses once, the FIFO stays empty, and the next good frame 0x29 is received correctly.
- Five frames with code_ready=0 and FIFO_DEPTH=4: four are stored and the fifth pulses err_overflow. With PS2_RX_INHIBIT_EN, ps2_clk_oe=1 after the third frame.
- Stall after 4 data bits for TIMEOUT_CYCLES: err_frame pulses and the FSM returns to IDLE; a following frame 0x5A is received correctly.
- A 3-cycle glitch low on ps2_clk (< FILTER_LEN) mid-frame: no extra bit is sampled and 0x1C is received intact. Reset asserted mid-frame: code_valid=0 and no error pulses follow.
